// File: rtl/usb_proto_pkg.sv
// Shared definitions for the USB FIFO bridge: protocol bytes, ERR bit layout
// and the read-strobe tracker state encoding.
package usb_proto_pkg;

  localparam logic [7:0] REQUEST_BYTE   = 8'h6C;
  localparam logic [7:0] CONFIRM_BYTE   = 8'h6D;
  localparam logic [7:0] START_REC_BYTE = 8'h73;

  localparam int ERR_W           = 3;
  localparam int ERR_RX_OVF      = 0;
  localparam int ERR_RD_UNDERRUN = 1;
  localparam int ERR_TX_OVF      = 2;

  // RD_REJECT marks a strobe that began on an empty RX FIFO and must not pop.
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ACTIVE,
    RD_REJECT
  } rd_state_e;

endpackage

// File: rtl/usb_byte_fifo.sv
// Synchronous byte FIFO with registered occupancy; push while full and pop
// while empty are ignored.
module usb_byte_fifo #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       wdata,
  input  logic             pop,
  output logic [7:0]       rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/usb_fifo_responder.sv
// Device-side responder for an FT245-style parallel USB FIFO: controller
// strobes on one side, host-side push/pop on the other.
module usb_fifo_responder
  import usb_proto_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int RXF_GAP = 1
) (
  input  logic             USB_CLK,
  input  logic             RST,
  input  logic             OE_N,
  input  logic             RD_N,
  input  logic             WR_N,
  input  logic [7:0]       DIN,
  output logic [7:0]       DOUT,
  output logic             RXF_N,
  output logic             TXE_N,
  input  logic             HOST_PUSH,
  input  logic [7:0]       HOST_WDATA,
  output logic             HOST_FULL,
  input  logic             HOST_POP,
  output logic [7:0]       HOST_RDATA,
  output logic             HOST_VALID,
  output logic [ERR_W-1:0] ERR
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int GAP_W = (RXF_GAP < 1) ? 1 : $clog2(RXF_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RXF_GAP);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  logic [7:0]       rx_head;
  logic             rx_full;
  logic             rx_empty;
  logic [CNT_W-1:0] rx_count;
  logic             rx_pop;

  logic [7:0]       tx_head;
  logic             tx_full;
  logic             tx_empty;
  logic [CNT_W-1:0] tx_count;

  rd_state_e        rd_state;
  rd_state_e        rd_next;
  logic             wr_prev_n;
  logic             wr_edge;
  logic             txe_hold;
  logic [GAP_W-1:0] gap_cnt;

  usb_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (USB_CLK),
    .rst   (RST),
    .push  (HOST_PUSH),
    .wdata (HOST_WDATA),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  usb_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (USB_CLK),
    .rst   (RST),
    .push  (wr_edge),
    .wdata (DIN),
    .pop   (HOST_POP),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  always_ff @(posedge USB_CLK or posedge RST) begin
    if (RST) begin
      rd_state <= RD_IDLE;
    end else begin
      rd_state <= rd_next;
    end
  end

  // A strobe decides at its leading edge whether it will pop on completion.
  always_comb begin
    rd_next = rd_state;
    rx_pop  = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (!RD_N) begin
          rd_next = rx_empty ? RD_REJECT : RD_ACTIVE;
        end
      end
      RD_ACTIVE: begin
        if (RD_N) begin
          rd_next = RD_IDLE;
          rx_pop  = 1'b1;
        end
      end
      RD_REJECT: begin
        if (RD_N) begin
          rd_next = RD_IDLE;
        end
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  assign wr_edge = wr_prev_n && !WR_N;

  always_ff @(posedge USB_CLK or posedge RST) begin
    if (RST) begin
      wr_prev_n <= 1'b1;
      txe_hold  <= 1'b0;
      gap_cnt   <= '0;
      ERR       <= '0;
    end else begin
      wr_prev_n <= WR_N;
      txe_hold  <= wr_edge && !tx_full;
      if (rx_pop) begin
        gap_cnt <= GAP_LOAD;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_ONE;
      end
      if (HOST_PUSH && rx_full) begin
        ERR[ERR_RX_OVF] <= 1'b1;
      end
      if (!RD_N && rx_empty) begin
        ERR[ERR_RD_UNDERRUN] <= 1'b1;
      end
      if (wr_edge && (tx_count == CNT_W'(DEPTH))) begin
        ERR[ERR_TX_OVF] <= 1'b1;
      end
    end
  end

  assign RXF_N      = !((rx_count != '0) && (gap_cnt == '0));
  assign DOUT       = (!OE_N && (rx_count != '0)) ? rx_head : 8'h00;
  assign TXE_N      = tx_full || txe_hold;
  assign HOST_FULL  = rx_full;
  assign HOST_VALID = !tx_empty;
  assign HOST_RDATA = tx_empty ? 8'h00 : tx_head;

endmodule

// File: tb/tb_usb_fifo_responder.sv
// Directed self-checking bench for usb_fifo_responder; byte queues model both
// FIFOs and supply the expected data for every controller read and host pop.
module tb_usb_fifo_responder;
  import usb_proto_pkg::*;

  localparam int DEPTH = 8;

  logic       USB_CLK = 1'b0;
  logic       RST;
  logic       OE_N;
  logic       RD_N;
  logic       WR_N;
  logic [7:0] DIN;
  logic [7:0] DOUT;
  logic       RXF_N;
  logic       TXE_N;
  logic       HOST_PUSH;
  logic [7:0] HOST_WDATA;
  logic       HOST_FULL;
  logic       HOST_POP;
  logic [7:0] HOST_RDATA;
  logic       HOST_VALID;
  logic [2:0] ERR;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [2:0] exp_err;

  usb_fifo_responder #(.DEPTH(DEPTH), .RXF_GAP(1)) dut (
    .USB_CLK    (USB_CLK),
    .RST        (RST),
    .OE_N       (OE_N),
    .RD_N       (RD_N),
    .WR_N       (WR_N),
    .DIN        (DIN),
    .DOUT       (DOUT),
    .RXF_N      (RXF_N),
    .TXE_N      (TXE_N),
    .HOST_PUSH  (HOST_PUSH),
    .HOST_WDATA (HOST_WDATA),
    .HOST_FULL  (HOST_FULL),
    .HOST_POP   (HOST_POP),
    .HOST_RDATA (HOST_RDATA),
    .HOST_VALID (HOST_VALID),
    .ERR        (ERR)
  );

  always #5 USB_CLK = ~USB_CLK;

  task automatic tick();
    @(negedge USB_CLK);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic oe_n, input logic rd_n,
                               input logic wr_n, input logic [7:0] din);
    OE_N = oe_n;
    RD_N = rd_n;
    WR_N = wr_n;
    DIN  = din;
  endtask

  task automatic hostPush(input logic [7:0] b);
    HOST_PUSH  = 1'b1;
    HOST_WDATA = b;
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else exp_err[ERR_RX_OVF] = 1'b1;
    tick();
    HOST_PUSH = 1'b0;
  endtask

  // Holds RD_N low for 'hold' cycles, checking DOUT each cycle, then completes.
  task automatic ctrlRead(input string tag, input int hold);
    logic [7:0] exp_d;
    bit         ok;
    ok    = (rx_q.size() > 0);
    exp_d = ok ? rx_q[0] : 8'h00;
    if (!ok) exp_err[ERR_RD_UNDERRUN] = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    repeat (hold) begin
      tick();
      checkOutput({tag, "_dout"}, DOUT, exp_d);
    end
    RD_N = 1'b1;
    tick();
    if (ok) void'(rx_q.pop_front());
    checkOutput({tag, "_rxf_after"}, RXF_N, 1'b1);
    checkOutput({tag, "_err"}, ERR, exp_err);
    OE_N = 1'b1;
  endtask

  task automatic ctrlWrite(input string tag, input logic [7:0] b, input int hold);
    if (tx_q.size() < DEPTH) tx_q.push_back(b);
    else exp_err[ERR_TX_OVF] = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, b);
    tick();
    checkOutput({tag, "_txe_busy"}, TXE_N, 1'b1);
    repeat (hold - 1) tick();
    WR_N = 1'b1;
    tick();
    checkOutput({tag, "_txe"}, TXE_N, tx_q.size() == DEPTH);
    checkOutput({tag, "_err"}, ERR, exp_err);
  endtask

  task automatic hostPop(input string tag);
    checkOutput({tag, "_valid"}, HOST_VALID, tx_q.size() > 0);
    if (tx_q.size() > 0) checkOutput({tag, "_rdata"}, HOST_RDATA, tx_q[0]);
    HOST_POP = 1'b1;
    tick();
    HOST_POP = 1'b0;
    if (tx_q.size() > 0) void'(tx_q.pop_front());
  endtask

  initial begin
    RST        = 1'b1;
    HOST_PUSH  = 1'b0;
    HOST_WDATA = 8'h00;
    HOST_POP   = 1'b0;
    exp_err    = 3'b000;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
    tick();
    tick();
    checkOutput("rst_rxf", RXF_N, 1'b1);
    checkOutput("rst_txe", TXE_N, 1'b0);
    checkOutput("rst_dout", DOUT, 8'h00);
    checkOutput("rst_full", HOST_FULL, 1'b0);
    checkOutput("rst_valid", HOST_VALID, 1'b0);
    checkOutput("rst_err", ERR, 3'b000);
    RST = 1'b0;
    tick();

    // Single request byte read by the controller
    hostPush(REQUEST_BYTE);
    checkOutput("req_rxf_ready", RXF_N, 1'b0);
    checkOutput("req_dout_oe_high", DOUT, 8'h00);
    ctrlRead("req_read", 1);
    tick();
    checkOutput("req_rxf_empty", RXF_N, 1'b1);

    // One long write strobe must produce exactly one TX entry
    ctrlWrite("confirm", CONFIRM_BYTE, 3);
    checkOutput("confirm_valid", HOST_VALID, 1'b1);
    checkOutput("confirm_rdata", HOST_RDATA, CONFIRM_BYTE);
    hostPop("confirm_pop");
    checkOutput("confirm_single", HOST_VALID, 1'b0);

    // RXF gap: forced high one cycle after a pop, then low again with data left
    hostPush(START_REC_BYTE);
    hostPush(8'hA2);
    ctrlRead("gap_rd0", 2);
    tick();
    checkOutput("gap_rxf_back", RXF_N, 1'b0);
    ctrlRead("gap_rd1", 1);

    // Host push coinciding with the read completion
    hostPush(8'hB1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    checkOutput("simul_dout", DOUT, 8'hB1);
    RD_N       = 1'b1;
    HOST_PUSH  = 1'b1;
    HOST_WDATA = 8'hB2;
    tick();
    HOST_PUSH = 1'b0;
    OE_N      = 1'b1;
    void'(rx_q.pop_front());
    rx_q.push_back(8'hB2);
    ctrlRead("simul_rd", 1);

    // Read strobe on an empty RX FIFO
    ctrlRead("underrun", 1);
    tick();
    checkOutput("underrun_rxf", RXF_N, 1'b1);
    checkOutput("underrun_full", HOST_FULL, 1'b0);

    // RX overflow: ninth push dropped, first eight come back in order
    for (int i = 0; i < 9; i++) begin
      hostPush(8'h10 + 8'(i));
      if (i == 7) checkOutput("rxovf_full", HOST_FULL, 1'b1);
    end
    checkOutput("rxovf_err", ERR, exp_err);
    for (int i = 0; i < 8; i++) ctrlRead($sformatf("rxovf_rd%0d", i), 1);
    tick();
    checkOutput("rxovf_drained", RXF_N, 1'b1);

    // TX overflow: ninth write discarded
    for (int i = 0; i < 9; i++) ctrlWrite($sformatf("txovf_wr%0d", i), 8'h80 + 8'(i), 1);
    for (int i = 0; i < 8; i++) hostPop($sformatf("txovf_pop%0d", i));
    hostPop("txovf_empty");

    // TX write coinciding with a host pop
    ctrlWrite("txsim_a", 8'hC1, 1);
    HOST_POP = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hC2);
    tick();
    HOST_POP = 1'b0;
    WR_N     = 1'b1;
    void'(tx_q.pop_front());
    tx_q.push_back(8'hC2);
    tick();
    hostPop("txsim_pop");
    checkOutput("txsim_empty", HOST_VALID, 1'b0);

    // Reset during a read strobe with two bytes queued
    hostPush(8'hD1);
    hostPush(8'hD2);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    checkOutput("rstmid_dout", DOUT, 8'hD1);
    RST = 1'b1;
    tick();
    checkOutput("rstmid_rxf", RXF_N, 1'b1);
    checkOutput("rstmid_dout0", DOUT, 8'h00);
    checkOutput("rstmid_err", ERR, 3'b000);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
    tick();
    RST = 1'b0;
    rx_q.delete();
    tx_q.delete();
    exp_err = 3'b000;
    tick();
    checkOutput("rstmid_release_rxf", RXF_N, 1'b1);
    checkOutput("rstmid_release_err", ERR, 3'b000);
    hostPush(8'hE5);
    ctrlRead("rstmid_after", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_fifo_responder.md
USB_FIFO_RESPONDER -- requirements
Module: usb_fifo_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning entries per byte FIFO (power of two, 2..64).
REQ-002 SHALL have parameter RXF_GAP, default 1, meaning USB_CLK cycles RXF_N is forced high after each completed read.
REQ-003 SHALL have port USB_CLK  in  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port OE_N  in  1  controller output-enable request, active-low.
REQ-006 SHALL have port RD_N  in  1  controller read strobe, active-low.
REQ-007 SHALL have port WR_N  in  1  controller write strobe, active-low.
REQ-008 SHALL have port DIN  in  8  byte driven by controller during a write.
REQ-009 SHALL have port DOUT  out  8  byte presented to controller.
REQ-010 SHALL have port RXF_N  out  1  low = byte available for the controller to read.
REQ-011 SHALL have port TXE_N  out  1  low = space available for the controller to write.
REQ-012 SHALL have ports HOST_PUSH in 1 / HOST_WDATA in 8 / HOST_FULL out 1: host-side load into the RX FIFO.
REQ-013 SHALL have ports HOST_POP in 1 / HOST_RDATA out 8 / HOST_VALID out 1: host-side drain of the TX FIFO.
REQ-014 SHALL have port ERR  out  3  sticky flags {TX_OVF, RD_UNDERRUN, RX_OVF}.

Function
REQ-015 SHALL assert RXF_N low only when the RX FIFO is non-empty and no RXF gap is running; high otherwise.
REQ-016 SHALL drive DOUT with the RX FIFO head byte while OE_N is low and the RX FIFO is non-empty; 8'h00 otherwise.
REQ-017 SHALL pop the RX FIFO once on the first rising edge where RD_N is sampled high after being sampled low (read completion).
REQ-018 SHALL hold DOUT stable on the head byte for the entire RD_N low interval; the pop takes effect on the completion cycle.
REQ-019 SHALL force RXF_N high for RXF_GAP cycles starting the cycle after a pop, then re-evaluate against FIFO occupancy.
REQ-020 SHALL set RD_UNDERRUN when RD_N is sampled low while the RX FIFO is empty; no pop occurs for that strobe.
REQ-021 SHALL assert TXE_N low when the TX FIFO has space; high when full and for one cycle after each accepted write.
REQ-022 SHALL capture DIN into the TX FIFO once, on the first cycle WR_N is sampled low after being sampled high; a WR_N low held several cycles is one write.
REQ-023 SHALL set TX_OVF and discard the byte on a write edge while the TX FIFO is full.
REQ-024 SHALL accept HOST_PUSH when not full; push while full SHALL be dropped and set RX_OVF, even if a controller pop occurs the same cycle.
REQ-025 SHALL allow simultaneous RX push and pop (non-full) with occupancy unchanged and order preserved.
REQ-026 SHALL present the TX FIFO head on HOST_RDATA with HOST_VALID high when non-empty; HOST_POP while empty is ignored.
REQ-027 SHALL allow simultaneous TX write and HOST_POP with occupancy unchanged.
REQ-028 SHALL wrap read/write pointers modulo DEPTH and derive full/empty from a DEPTH+1-state count.
REQ-029 SHALL have zero-cycle latency from FIFO state to flags (flags registered with occupancy, no extra pipeline stage).

Reset
REQ-030 SHALL on RST: empty both FIFOs, clear ERR to 3'b000, RXF_N=1, TXE_N=0, DOUT=8'h00, HOST_FULL=0, HOST_VALID=0, RXF gap counter cleared.
REQ-031 SHALL reset sampled strobe history to RD_N=1, WR_N=1 so no spurious edge is detected on release.
REQ-032 SHALL abandon any in-progress read or write when RST is asserted mid-strobe; no pop or capture on release.

Structure
REQ-033 SHALL import shared package usb_proto_pkg holding protocol bytes REQUEST_BYTE=8'h6C, CONFIRM_BYTE=8'h6D, START_REC_BYTE=8'h73 and ERR bit indices.
REQ-034 SHALL instantiate sub-module usb_byte_fifo (sync, parameterised DEPTH, push/pop/full/empty/count) twice: RX and TX.
REQ-035 SHALL keep edge detection and RXF gap counter in this module, outside usb_byte_fifo.

Verification
REQ-036 SHALL cover: push 8'h6C, then OE_N low, RD_N low 1 cycle -> DOUT=8'h6C during strobe, RXF_N high for 1 cycle then high (empty).
REQ-037 SHALL cover: controller writes 8'h6D with WR_N low 3 cycles -> exactly one TX entry, HOST_RDATA=8'h6D, HOST_VALID=1.
REQ-038 SHALL cover: push 9 bytes with DEPTH=8 -> HOST_FULL=1 after 8th, 9th dropped, ERR[0]=1, 8 bytes read back in order.
REQ-039 SHALL cover: RD_N low with RX empty -> ERR[1]=1, DOUT=8'h00, occupancy stays 0.
REQ-040 SHALL cover: 9 writes without HOST_POP -> TXE_N high after 8th, ERR[2]=1, TX content = first 8 bytes.
REQ-041 SHALL cover: RST asserted during RD_N low with 2 bytes queued -> RX empty, RXF_N=1, no pop on release.
